// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: controller states,
// scoreboard entry layout and the per-entry register compare helper.
package hazard_ctrl_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

    // One in-flight instruction: v marks a real register writer, h marks HALT.
    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
        logic             h;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: 3'd0, h: 1'b0};

    function automatic logic entry_hit(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.v && (e.rd == r);
    endfunction

endpackage

// File: rtl/hazard_sb.sv
// Three-entry destination scoreboard (X, M, W) with hold/advance control and
// two source-register compare ports.
module hazard_sb
    import hazard_ctrl_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             kill_h,
    input  logic             new_v,
    input  logic [REG_W-1:0] new_rd,
    input  logic             new_h,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    output logic             rs_match,
    output logic             rt_match,
    output logic [2:0]       valid,
    output logic             w_h
);

    sb_entry_t x_r;
    sb_entry_t m_r;
    sb_entry_t w_r;
    sb_entry_t new_s;
    sb_entry_t m_in_s;

    // Build the incoming X entry and the X->M entry, optionally dropping a squashed HALT.
    always_comb begin
        new_s  = '{v: new_v, rd: new_rd, h: new_h};
        m_in_s = x_r;
        if (kill_h) begin
            m_in_s.h = 1'b0;
        end else begin
            m_in_s.h = x_r.h;
        end
    end

    // Scoreboard shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= SB_EMPTY;
            m_r <= SB_EMPTY;
            w_r <= SB_EMPTY;
        end else if (advance) begin
            w_r <= m_r;
            m_r <= m_in_s;
            x_r <= new_s;
        end else begin
            x_r <= x_r;
            m_r <= m_r;
            w_r <= w_r;
        end
    end

    // Source compares; a W hit only matters when the register file cannot bypass it.
    always_comb begin
        rs_match = entry_hit(x_r, rs) || entry_hit(m_r, rs) ||
                   (!WB_BYPASS && entry_hit(w_r, rs));
        rt_match = entry_hit(x_r, rt) || entry_hit(m_r, rt) ||
                   (!WB_BYPASS && entry_hit(w_r, rt));
        valid    = {w_r.v, m_r.v, x_r.v};
        w_h      = w_r.h;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: RAW stalls, redirect squash, memory freeze
// and HALT drain for the 5-stage core (no forwarding, every hazard stalls).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_halt,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             stall_f,
    output logic             stall_d,
    output logic             nop_d,
    output logic             flush_f,
    output logic [2:0]       sb_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ctrl_state_e      state_r;
    ctrl_state_e      state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             advance_s;
    logic             kill_h_s;
    logic             new_v_s;
    logic [REG_W-1:0] new_rd_s;
    logic             new_h_s;
    logic             rs_match_s;
    logic             rt_match_s;
    logic             raw_s;
    logic             w_h_s;
    logic [2:0]       sb_valid_s;

    hazard_sb #(
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance_s),
        .kill_h   (kill_h_s),
        .new_v    (new_v_s),
        .new_rd   (new_rd_s),
        .new_h    (new_h_s),
        .rs       (id_rs),
        .rt       (id_rt),
        .rs_match (rs_match_s),
        .rt_match (rt_match_s),
        .valid    (sb_valid_s),
        .w_h      (w_h_s)
    );

    assign raw_s     = id_valid && ((id_rs_used && rs_match_s) || (id_rt_used && rt_match_s));
    assign sb_valid  = sb_valid_s;
    assign stall_cnt = cnt_r;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, pipeline controls and scoreboard commands; reset forces all controls low.
    always_comb begin
        state_s   = state_r;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        nop_d     = 1'b0;
        flush_f   = 1'b0;
        halted    = 1'b0;
        advance_s = 1'b0;
        kill_h_s  = 1'b0;
        new_v_s   = 1'b0;
        new_rd_s  = 3'd0;
        new_h_s   = 1'b0;
        if (rst) begin
            state_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_busy) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                    end else if (ex_redirect) begin
                        // Decode instruction is on the wrong path; its hazard is irrelevant.
                        flush_f   = 1'b1;
                        nop_d     = 1'b1;
                        advance_s = 1'b1;
                    end else if (raw_s) begin
                        stall_f   = 1'b1;
                        nop_d     = 1'b1;
                        advance_s = 1'b1;
                    end else if (id_valid && id_halt) begin
                        advance_s = 1'b1;
                        new_rd_s  = id_rd;
                        new_h_s   = 1'b1;
                        state_s   = DRAIN;
                    end else begin
                        advance_s = 1'b1;
                        new_v_s   = id_valid && id_regwrite;
                        new_rd_s  = id_rd;
                    end
                end
                DRAIN: begin
                    if (mem_busy) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                    end else if (ex_redirect) begin
                        // An older branch wins: the HALT still in X is cancelled as it moves on.
                        flush_f   = 1'b1;
                        nop_d     = 1'b1;
                        advance_s = 1'b1;
                        kill_h_s  = 1'b1;
                        state_s   = RUN;
                    end else begin
                        stall_f   = 1'b1;
                        nop_d     = 1'b1;
                        advance_s = 1'b1;
                        if (w_h_s) begin
                            state_s = HALTED;
                        end else begin
                            state_s = DRAIN;
                        end
                    end
                end
                HALTED: begin
                    stall_f = 1'b1;
                    nop_d   = 1'b1;
                    halted  = 1'b1;
                end
                default: begin
                    state_s = RUN;
                end
            endcase
        end
    end

    // Saturating count of stalled fetch cycles, not counting the parked HALTED state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (stall_f && (state_r != HALTED) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// against a pipeline-occupancy reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_halt;
    logic [2:0] id_rs, id_rt, id_rd;
    logic       ex_redirect, mem_busy;

    logic        stall_f, stall_d, nop_d, flush_f, halted;
    logic [2:0]  sb_valid;
    logic [15:0] stall_cnt;

    logic        s_stall_f, s_stall_d, s_nop_d, s_flush_f, s_halted;
    logic [2:0]  s_sb_valid;
    logic [3:0]  s_stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_f(stall_f), .stall_d(stall_d), .nop_d(nop_d), .flush_f(flush_f),
        .sb_valid(sb_valid), .halted(halted), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_halt(id_halt), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .nop_d(s_nop_d), .flush_f(s_flush_f),
        .sb_valid(s_sb_valid), .halted(s_halted), .stall_cnt(s_stall_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what sits in EX/MEM/WB (index 0/1/2) and whether we drain or are halted.
    bit       mv[3];
    bit [2:0] mrd[3];
    bit       mh[3];
    bit       m_drain, m_halt;
    int       m_cnt;

    // Expectations for the current cycle and the effect of the coming edge.
    bit       e_sf, e_sd, e_nop, e_fl, e_adv, e_kill, e_nv, e_nh, e_drain_n, e_halt_n;
    bit [2:0] e_nrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_flight(input bit [2:0] r);
        return (mv[0] && mrd[0] == r) || (mv[1] && mrd[1] == r);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0; mrd[i] = 3'd0; mh[i] = 1'b0;
        end
        m_drain = 1'b0;
        m_halt  = 1'b0;
        m_cnt   = 0;
    endfunction

    task automatic set_id(input bit v, input bit [2:0] rs, input bit rsu, input bit [2:0] rt,
                          input bit rtu, input bit [2:0] rd, input bit rw, input bit hl);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd; id_regwrite = rw; id_halt = hl;
    endtask

    task automatic idle();
        set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
    endtask

    // Mid-cycle: derive expected behaviour from the rules and compare every output.
    task automatic settle();
        bit raw;
        @(negedge clk);
        e_sf = 0; e_sd = 0; e_nop = 0; e_fl = 0; e_adv = 0; e_kill = 0;
        e_nv = 0; e_nh = 0; e_nrd = 3'd0;
        e_drain_n = m_drain; e_halt_n = m_halt;
        raw = id_valid && ((id_rs_used && in_flight(id_rs)) || (id_rt_used && in_flight(id_rt)));
        if (rst) begin
        end else if (m_halt) begin
            e_sf = 1; e_nop = 1;
        end else if (mem_busy) begin
            e_sf = 1; e_sd = 1;
        end else if (m_drain) begin
            e_adv = 1;
            if (ex_redirect) begin
                e_fl = 1; e_nop = 1; e_kill = 1; e_drain_n = 0;
            end else begin
                e_sf = 1; e_nop = 1;
                if (mh[2]) begin e_drain_n = 0; e_halt_n = 1; end
            end
        end else begin
            e_adv = 1;
            if (ex_redirect) begin
                e_fl = 1; e_nop = 1;
            end else if (raw) begin
                e_sf = 1; e_nop = 1;
            end else if (id_valid && id_halt) begin
                e_nh = 1; e_nrd = id_rd; e_drain_n = 1;
            end else begin
                e_nv = id_valid && id_regwrite; e_nrd = id_rd;
            end
        end
        chk("stall_f", stall_f, e_sf);
        chk("stall_d", stall_d, e_sd);
        chk("nop_d", nop_d, e_nop);
        chk("flush_f", flush_f, e_fl);
        chk("halted", halted, !rst && m_halt);
        chk("sb_valid", sb_valid, {mv[2], mv[1], mv[0]});
        chk("stall_cnt", stall_cnt, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("stall_cnt_sat", s_stall_cnt, (m_cnt > 15) ? 15 : m_cnt);
    endtask

    // Clock edge: move the model forward.
    task automatic adv();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (e_sf && !m_halt) m_cnt++;
            if (e_adv) begin
                mv[2] = mv[1]; mrd[2] = mrd[1]; mh[2] = mh[1];
                mv[1] = mv[0]; mrd[1] = mrd[0]; mh[1] = mh[0] && !e_kill;
                mv[0] = e_nv;  mrd[0] = e_nrd;  mh[0] = e_nh;
            end
            m_drain = e_drain_n;
            m_halt  = e_halt_n;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        settle(); adv();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        model_clear();
        rst = 1'b0;

        // Reset state
        settle();
        chk("rst_stall_f", stall_f, 1'b0);
        chk("rst_sb", sb_valid, 3'b000);
        chk("rst_cnt", stall_cnt, 16'd0);
        adv();

        // Back-to-back dependency on r1: two stall cycles, issue on the third
        do_reset();
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0); settle(); adv();
        set_id(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0);
        settle(); chk("b2b_c1_stall", stall_f, 1'b1); chk("b2b_c1_nop", nop_d, 1'b1); adv();
        settle(); chk("b2b_c2_stall", stall_f, 1'b1); chk("b2b_c2_nop", nop_d, 1'b1); adv();
        settle(); chk("b2b_c3_issue", stall_f, 1'b0); chk("b2b_cnt", stall_cnt, 16'd2); adv();
        idle();

        // Independent stream fills the scoreboard without stalling
        do_reset();
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 0); settle(); chk("ind_1", stall_f, 1'b0); adv();
        set_id(1, 3'd2, 1, 3'd3, 1, 3'd4, 1, 0);
        settle(); chk("ind_sb1", sb_valid, 3'b001); chk("ind_2", stall_f, 1'b0); adv();
        set_id(1, 3'd6, 1, 3'd7, 1, 3'd5, 1, 0);
        settle(); chk("ind_sb2", sb_valid, 3'b011); chk("ind_3", stall_f, 1'b0); adv();
        idle();
        settle(); chk("ind_sb3", sb_valid, 3'b111); adv();

        // Taken branch while decode has a RAW on r4
        do_reset();
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0); settle(); adv();
        set_id(1, 3'd4, 1, 3'd0, 0, 3'd2, 1, 0); ex_redirect = 1'b1;
        settle();
        chk("br_flush", flush_f, 1'b1); chk("br_nop", nop_d, 1'b1); chk("br_stall", stall_f, 1'b0);
        adv();
        idle();
        settle(); chk("br_sb", sb_valid, 3'b010); chk("br_cnt", stall_cnt, 16'd0); adv();

        // Memory busy for three cycles over a pending hazard on r3
        do_reset();
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0); settle(); adv();
        set_id(1, 3'd0, 0, 3'd3, 1, 3'd6, 1, 0); mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("mb_stall_d", stall_d, 1'b1); chk("mb_nop", nop_d, 1'b0); chk("mb_sb", sb_valid, 3'b001);
            adv();
        end
        mem_busy = 1'b0;
        settle(); chk("mb_raw1", stall_f, 1'b1); chk("mb_raw1_sd", stall_d, 1'b0); adv();
        settle(); chk("mb_raw2", stall_f, 1'b1); adv();
        settle(); chk("mb_issue", stall_f, 1'b0); chk("mb_cnt", stall_cnt, 16'd5); adv();
        idle();

        // HALT behind an r5 writer: drain, park, then reset
        do_reset();
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0); settle(); adv();
        set_id(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1); settle(); chk("h_issue", stall_f, 1'b0); adv();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle(); chk("h_drain_halted", halted, 1'b0); chk("h_drain_stall", stall_f, 1'b1); adv();
        end
        settle(); chk("h_halted1", halted, 1'b1); adv();
        settle(); chk("h_halted2", halted, 1'b1); adv();
        rst = 1'b1;
        settle(); chk("h_rst_halted", halted, 1'b0); chk("h_rst_stall", stall_f, 1'b0); adv();
        rst = 1'b0;
        settle(); chk("h_cnt_clr", stall_cnt, 16'd0); chk("h_after_rst", halted, 1'b0); adv();

        // Counter saturation: 20 frozen cycles
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            settle(); adv();
        end
        mem_busy = 1'b0;
        settle(); chk("sat_cnt4", s_stall_cnt, 4'd15); chk("sat_cnt16", stall_cnt, 16'd20); adv();

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom_range(99) < 2);
            id_valid    = ($urandom_range(9) < 8);
            id_rs       = 3'($urandom_range(7));
            id_rs_used  = $urandom_range(1) == 1;
            id_rt       = 3'($urandom_range(7));
            id_rt_used  = $urandom_range(1) == 1;
            id_rd       = 3'($urandom_range(7));
            id_regwrite = ($urandom_range(3) != 0);
            id_halt     = ($urandom_range(39) == 0);
            mem_busy    = ($urandom_range(99) < 15);
            ex_redirect = ($urandom_range(99) < 10);
            settle(); adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Tracks destination registers of in-flight instructions in EX/MEM/WB with an internal scoreboard. Detects RAW hazards against the instruction in decode.
- Drives stall/bubble controls for the PC, IF/ID and the ID/EX register (stall, nop_d), squashes on taken redirects, freezes on memory busy, and drains/halts the pipeline on HALT.
- No forwarding network exists; every RAW hazard is resolved by stalling.

Parameters:
- WB_BYPASS, 1, 1 = register file is write-before-read, so a WB-stage match is not a hazard; 0 = WB match also stalls.
- CNT_W, 16, width of saturating stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs  in  3  source register 1
- id_rs_used  in  1  instruction reads id_rs
- id_rt  in  3  source register 2
- id_rt_used  in  1  instruction reads id_rt
- id_rd  in  3  destination register
- id_regwrite  in  1  instruction writes id_rd
- id_halt  in  1  decode holds HALT
- ex_redirect  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data/instruction memory not ready; freeze whole pipe
- stall_f  out  1  hold PC and IF/ID
- stall_d  out  1  hold ID/EX contents (ID/EX stall input)
- nop_d  out  1  inject bubble into ID/EX (ID/EX nop_d input)
- flush_f  out  1  squash IF/ID to a nop
- sb_valid  out  3  scoreboard valid bits {W,M,X}, debug
- halted  out  1  sticky, HALT has retired
- stall_cnt  out  CNT_W  cycles with stall_f=1, saturating

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- Reset: all scoreboard entries invalid; state RUN; stall_cnt=0; halted=0.
- Outputs are combinational from state/scoreboard/inputs, so they settle in the same cycle.
- Scoreboard: three entries X, M, W, each {v, rd[2:0], h}.
  - Advance: W<=M, M<=X, X<=new.
  - Hold: no change.
- match(r) = (X.v & X.rd==r) | (M.v & M.rd==r) | (!WB_BYPASS & W.v & W.rd==r).
- raw = id_valid & ((id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt))).
- X.v is set only for real register writers. A separate h bit marks HALT; HALT entries have v=0, h=1.
- State RUN, per-cycle priority (first true wins):
  1. mem_busy: stall_f=1, stall_d=1, nop_d=0, flush_f=0; scoreboard hold.
  2. ex_redirect: flush_f=1, nop_d=1, stall_f=0; advance with new=invalid. Decode instruction is squashed; a raw in the same cycle is ignored.
  3. raw: stall_f=1, nop_d=1; advance with new=invalid. The bubble moves ahead and the consumer re-checks next cycle.
  4. id_valid & id_halt: advance with new={0,x,1}; next state DRAIN.
  5. Otherwise: all controls 0; advance with new={id_valid&id_regwrite, id_rd, 0}.
- State DRAIN: stall_f=1, nop_d=1, advance with new=invalid.
  - Exception: mem_busy gives stall_f=1, stall_d=1, nop_d=0, hold.
  - ex_redirect in DRAIN: an older branch was still in EX. Squash HALT by clearing the X.h bit on advance (HALT not yet past EX), assert flush_f=1, return to RUN.
  - When W.h=1 and !mem_busy: next state HALTED.
- State HALTED: halted=1, stall_f=1, nop_d=1, scoreboard hold; exits only on rst.
- Redirect timing: ex_redirect refers to the instruction currently in X. It advances normally into M; only the incoming entry becomes a bubble.
- stall_cnt: +1 each cycle stall_f=1 and state!=HALTED; saturates at all-ones.
- Reset mid-stall or mid-drain: all state cleared on the next edge; outputs return to 0 in the reset cycle.
- Invariants: stall_d=1 only together with mem_busy; nop_d and stall_d are never both 1.

Decomposition:
- Shared package holds:
  - Controller state encoding: RUN=2'd0, DRAIN=2'd1, HALTED=2'd2.
  - Scoreboard entry field widths.
  - REG_W=3.
- Natural sub-module: hazard_sb, the 3-entry scoreboard shift register with hold/advance/new-entry inputs and the match comparators, instantiated twice in match logic (rs, rt) or once with two compare ports.
- FSM, priority logic and counter stay in hazard_ctrl.

Test Plan:
- Back-to-back dependency: ADD r1 writes, next instruction reads rs=r1 (WB_BYPASS=1) -> stall_f=1 and nop_d=1 for exactly 2 cycles; issues on cycle 3; stall_cnt=2.
- Independent stream: rd=r1, then rs=r2, rt=r3 -> no stall; sb_valid goes 001, 011, 111.
- Taken branch in EX while decode has a RAW on r4 -> flush_f=1, nop_d=1, stall_f=0 for 1 cycle; stall_cnt unchanged; X entry invalid next cycle.
- mem_busy held 3 cycles during a pending hazard -> stall_f=stall_d=1, nop_d=0 for 3 cycles; sb_valid frozen; hazard resolution resumes after.
- HALT issued with r5 writer ahead -> DRAIN; halted=1 on the cycle after HALT reaches W (3 cycles after issue); stays 1; rst clears it and stall_cnt to 0.
- Saturation with CNT_W=4: force 20 stall cycles -> stall_cnt=15.
